// File: rtl/nibble_serializer.sv
// Captures a 4*N_NIB-bit word and replays it MS-nibble first over a
// valid/ready handshake, pulsing done once after the final transfer.
module nibble_serializer #(
  parameter int N_NIB = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [4*N_NIB-1:0]         word_in,
  input  logic                       nib_ready,
  output logic [3:0]                 nib_out,
  output logic                       nib_valid,
  output logic                       nib_last,
  output logic [$clog2(N_NIB)-1:0]   nib_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int W  = 4 * N_NIB;
  localparam int CW = $clog2(N_NIB);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            send;
  logic            at_last;

  assign send    = (state_q == SEND);
  assign at_last = (cnt_q == CW'(N_NIB - 1));

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          sh_d    = word_in;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // load is deliberately not examined here, so the in-flight word is safe
        if (nib_ready) begin
          if (at_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            sh_d  = {sh_q[W-5:0], 4'h0};
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs derive from registered state only; nib_ready never reaches nib_valid.
  assign nib_valid = send;
  assign busy      = send;
  assign nib_out   = send ? sh_q[W-1 -: 4] : 4'h0;
  assign nib_last  = send & at_last;
  assign nib_idx   = send ? cnt_q : '0;
  assign done      = done_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer: constant vector table, directed
// corner sequences, and randomized traffic against a queue-based model.
module tb_nibble_serializer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] word_in = '0;
  logic        nib_ready = 1'b0;
  logic [3:0]  nib_out;
  logic        nib_valid;
  logic        nib_last;
  logic [1:0]  nib_idx;
  logic        busy;
  logic        done;

  nibble_serializer #(.N_NIB(N)) dut (
    .clk(clk), .rst(rst), .load(load), .word_in(word_in),
    .nib_ready(nib_ready), .nib_out(nib_out), .nib_valid(nib_valid),
    .nib_last(nib_last), .nib_idx(nib_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // reference model: queue of nibbles still to be delivered
  logic [3:0]  mq[$];
  logic [1:0]  midx = '0;
  logic        mdone = 1'b0;

  // observed stream, done pulses and a behavioural entry register for loopback
  logic [3:0]  got[$];
  int unsigned done_cnt = 0;
  logic [15:0] dato = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic r, input logic l, input logic [15:0] w, input logic rdy);
    if (r) begin
      mq.delete();
      midx  = '0;
      mdone = 1'b0;
    end else begin
      mdone = 1'b0;
      if (mq.size() > 0) begin
        if (rdy) begin
          void'(mq.pop_front());
          if (mq.size() == 0) mdone = 1'b1;
          else midx++;
        end
      end else if (l) begin
        for (int i = N - 1; i >= 0; i--) mq.push_back(w[4*i +: 4]);
        midx = '0;
      end
    end
  endtask

  // apply inputs for one rising edge, then compare every output against the model
  task automatic step(input logic r, input logic l, input logic [15:0] w, input logic rdy);
    rst = r; load = l; word_in = w; nib_ready = rdy;
    if (!r && nib_valid && rdy) begin
      got.push_back(nib_out);
      dato = {dato[11:0], nib_out};
    end
    @(posedge clk);
    model_edge(r, l, w, rdy);
    @(negedge clk);
    check("valid", nib_valid, mq.size() != 0);
    check("busy",  busy,      mq.size() != 0);
    check("out",   nib_out,   (mq.size() != 0) ? mq[0] : 4'h0);
    check("last",  nib_last,  mq.size() == 1);
    check("idx",   nib_idx,   (mq.size() != 0) ? midx : 2'd0);
    check("done",  done,      mdone);
    if (done) done_cnt++;
  endtask

  function automatic logic [31:0] got_word();
    logic [31:0] v = '0;
    foreach (got[i]) v = {v[27:0], got[i]};
    return v;
  endfunction

  // load a word, then clock with ready until done or budget expires
  task automatic send_word(input logic [15:0] w, input int unsigned ready_pct);
    int unsigned budget;
    step(1'b0, 1'b1, w, 1'b1);
    budget = 0;
    while (!done && budget < 64) begin
      step(1'b0, 1'b0, 16'h0, $urandom_range(99) < ready_pct);
      budget++;
    end
    check("send_budget", budget < 64, 1);
  endtask

  typedef struct {
    logic        r, l, rdy;
    logic [15:0] w;
    logic        ev;
    logic [3:0]  eout;
    logic        elast;
    logic [1:0]  eidx;
    logic        ebusy, edone;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{1, 0, 1, 16'h0000, 0, 4'h0, 0, 2'd0, 0, 0};
    vt[1] = '{0, 1, 1, 16'hA3F5, 1, 4'hA, 0, 2'd0, 1, 0};
    vt[2] = '{0, 0, 1, 16'h0000, 1, 4'h3, 0, 2'd1, 1, 0};
    vt[3] = '{0, 0, 1, 16'h0000, 1, 4'hF, 0, 2'd2, 1, 0};
    vt[4] = '{0, 0, 1, 16'h0000, 1, 4'h5, 1, 2'd3, 1, 0};
    vt[5] = '{0, 0, 1, 16'h0000, 0, 4'h0, 0, 2'd0, 0, 1};
    vt[6] = '{0, 0, 1, 16'h0000, 0, 4'h0, 0, 2'd0, 0, 0};

    for (int i = 0; i < 7; i++) begin
      step(vt[i].r, vt[i].l, vt[i].w, vt[i].rdy);
      check("tv_valid", nib_valid, vt[i].ev);
      check("tv_out",   nib_out,   vt[i].eout);
      check("tv_last",  nib_last,  vt[i].elast);
      check("tv_idx",   nib_idx,   vt[i].eidx);
      check("tv_busy",  busy,      vt[i].ebusy);
      check("tv_done",  done,      vt[i].edone);
    end

    // stalls: ready pattern 1,0,0,1,1,0,1 over the SEND cycles
    begin
      logic [6:0] pat;
      pat = 7'b1011001;
      got.delete(); done_cnt = 0;
      step(1'b0, 1'b1, 16'h1234, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 16'h0, pat[i]);
      check("stall_stream_len", got.size(), 4);
      check("stall_stream", got_word(), 32'h1234);
      check("stall_done", done, 1);
      check("stall_done_cnt", done_cnt, 1);
    end

    // load spam while busy, including the final-transfer cycle
    got.delete(); done_cnt = 0;
    step(1'b0, 1'b1, 16'hBEEF, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("spam_stream", got_word(), 32'hBEEF);
    check("spam_len", got.size(), 4);
    check("spam_idle", nib_valid, 0);

    // back-to-back load on the done cycle
    got.delete(); done_cnt = 0;
    step(1'b0, 1'b1, 16'hC0DE, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    check("b2b_done_seen", done, 1);
    step(1'b0, 1'b1, 16'h9876, 1'b1);
    check("b2b_restart", nib_out, 4'h9);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    check("b2b_stream", got_word(), 32'hC0DE9876);
    check("b2b_done_cnt", done_cnt, 2);

    // reset mid-word
    got.delete(); done_cnt = 0;
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'h1111, 1'b1);
    check("rst_out", {nib_valid, nib_out, nib_last, nib_idx, busy, done}, 0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("rst_no_done", done_cnt, 0);
    got.delete();
    send_word(16'h0001, 100);
    check("rst_after_stream", got_word(), 32'h0001);

    // loopback into an entry register
    begin
      logic [15:0] lb[3];
      lb[0] = 16'h5A5A; lb[1] = 16'h0000; lb[2] = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
        dato = 16'h3C3C ^ lb[i];
        send_word(lb[i], 60);
        check("loopback", dato, lb[i]);
      end
    end

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++)
      step($urandom_range(49) == 0, $urandom_range(2) == 0, 16'($urandom), $urandom_range(3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Transmit-side counterpart of the nibble-entry shift register. It captures a 16-bit word and replays it as a stream of 4-bit nibbles, most-significant nibble first. That order matches the order in which the entry register shifted the nibbles in. Each nibble is transferred under a valid/ready handshake. Consumers are downstream nibble sinks such as the hex display scanner, a UART hex formatter, or a second entry register in loopback tests.

## Interface
Parameters:
- N_NIB, 4, number of nibbles per word; word width is 4*N_NIB (16 by default).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  one-cycle request to capture word_in; honoured only when busy=0.
- word_in  in  4*N_NIB  word to serialize; sampled only on an accepted load.
- nib_ready  in  1  sink can accept the current nibble.
- nib_out  out  4  current nibble; valid only while nib_valid=1.
- nib_valid  out  1  nib_out holds a nibble awaiting transfer.
- nib_last  out  1  high with nib_valid when nib_out is the final (least-significant) nibble.
- nib_idx  out  $clog2(N_NIB)  index of the current nibble; 0 = most significant.
- busy  out  1  a word is being serialized; load is ignored.
- done  out  1  one-cycle pulse after the final nibble transfers.

## Operation
- Internal state:
  - shift register sh[4*N_NIB-1:0];
  - nibble counter cnt[$clog2(N_NIB)-1:0];
  - 2-state FSM with states IDLE and SEND;
  - registered done flag.
- IDLE:
  - busy=0, nib_valid=0.
  - If load=1: sh<=word_in, cnt<=0, go to SEND.
- SEND:
  - busy=1, nib_valid=1.
  - nib_out=sh[4*N_NIB-1 -: 4], nib_idx=cnt, nib_last=(cnt==N_NIB-1).
- Handshake: a transfer occurs in any SEND cycle with nib_valid & nib_ready.
  - On a transfer with nib_last=0: sh<={sh[4*N_NIB-5:0],4'h0}, cnt<=cnt+1.
  - On a transfer with nib_last=1: go to IDLE and set done<=1 for exactly one cycle.
- Stall: while nib_valid=1 and nib_ready=0, nib_out, nib_idx and nib_last hold stable. nib_valid never drops before its transfer.
- Load in SEND is ignored; the in-flight word is not corrupted. This includes a load in the same cycle as the final transfer.
- Load in the cycle done is high is legal, because the FSM is already in IDLE and busy=0.
- When nib_valid=0, nib_out is driven to 4'h0, and nib_last and nib_idx are driven to 0.
- Counter width rule: cnt never exceeds N_NIB-1. The final transfer returns to IDLE instead of incrementing cnt.
- Reset (also mid-word):
  - FSM enters IDLE; sh=0, cnt=0.
  - Outputs: nib_valid=0, nib_last=0, nib_idx=0, nib_out=0, busy=0, done=0.
  - The partial word is discarded and no done is generated.

## Timing
- Load accepted at edge t -> nib_valid=1 with the MS nibble from edge t+1.
- With nib_ready held high: one nibble per cycle, so an N_NIB-nibble word occupies N_NIB cycles of nib_valid.
- done goes high at the edge after the final transfer, the same edge at which busy falls. It stays high for 1 cycle.
- Minimum load-to-load spacing is N_NIB+1 cycles: N_NIB SEND cycles plus one IDLE cycle to accept the next load.
- nib_ready is ignored outside SEND. There is no combinational path from nib_ready to nib_valid.
- rst takes priority over load and over any handshake in the same cycle.

## Test plan
- Reset then load word_in=16'hA3F5, nib_ready=1 -> nib_out A,3,F,5 with nib_idx 0..3 on 4 consecutive cycles.
  - nib_last is high only on 5.
  - done pulses once, on the cycle after 5; busy high for exactly 4 cycles.
- Load 16'h1234 with nib_ready toggling 1,0,0,1,1,0,1 -> nib_out holds each nibble through the stalls.
  - The stream is exactly 1,2,3,4 with no duplicate or dropped nibble; done follows the transfer of 4.
- Load 16'hBEEF, then assert load with word_in=16'h0000 while busy=1, including the cycle of the final transfer -> stream remains B,E,E,F and no new word starts.
- Load 16'hC0DE, then load 16'h9876 in the cycle done is high -> C,0,D,E followed by one idle cycle, then 9,8,7,6.
- Load 16'hFFFF, assert rst after 2 transfers -> next cycle all outputs are 0 and no done appears.
  - A subsequent load of 16'h0001 streams 0,0,0,1.
- Loopback: drive the entry shift register from nib_out, with its button = nib_valid & nib_ready and bit_in[3:0] = nib_out.
  - For 16'h5A5A, 16'h0000 and 16'hFFFF, the entry register's dato equals word_in after done.
